// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding,
// default operand width and the sequence-counter width helper.
package serial_adder_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  // 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter width: max(1, clog2(width)).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_controller_if.sv
// Request/result bundle between an ALU sequencer (master) and the
// bit-serial adder (slave).
interface serial_adder_controller_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  modport master (
    output start, a, b, carryin,
    input  busy, done, sum, carryout, overflow
  );

  modport slave (
    input  start, a, b, carryin,
    output busy, done, sum, carryout, overflow
  );

endinterface

// File: rtl/structuralFullAdder.sv
// One-bit full adder built from gate primitives; the only arithmetic
// element of the serial adder.
module structuralFullAdder (
  output wire sum,
  output wire carryout,
  input  wire a,
  input  wire b,
  input  wire carryin
);

  wire ab_xor;
  wire ab_and;
  wire cin_and;

  xor u_xor_ab  (ab_xor, a, b);
  xor u_xor_sum (sum, ab_xor, carryin);
  and u_and_ab  (ab_and, a, b);
  and u_and_cin (cin_and, ab_xor, carryin);
  or  u_or_cout (carryout, ab_and, cin_and);

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one bit per clock, LSB
// first, with carry-out, signed overflow and a one-cycle done pulse.
module serial_adder_controller
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input logic                      clk,
  input logic                      reset,
  serial_adder_controller_if.slave bus
);

  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] ps_next;

  structuralFullAdder u_fa (
    .sum      (fa_sum),
    .carryout (fa_cout),
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carryin  (carry)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign ps_next = WIDTH'({fa_sum, ps_sh} >> 1);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, e.g. overflow reads carry before it updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shifters are plain flops, not a memory, so clearing them
      // is cheap and keeps the datapath deterministic after reset.
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      ps_sh        <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.carryout <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            carry    <= bus.carryin;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end

        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          ps_sh <= ps_next;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            // carry still holds the carry into the MSB during the final bit.
            bus.sum      <= ps_next;
            bus.carryout <= fa_cout;
            bus.overflow <= carry ^ fa_cout;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed bench for the bit-serial adder: an 8-bit instance for the main
// sequencing cases and a 1-bit instance for the single-cycle corner.
module tb_serial_adder_controller;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  serial_adder_controller_if #(.WIDTH(W)) bus  ();
  serial_adder_controller_if #(.WIDTH(1)) bus1 ();

  serial_adder_controller #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  serial_adder_controller #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the 8-bit DUT idle; returns at a negedge with it idle.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] exp_sum,
                        input logic exp_co, input logic exp_ov);
    int busy_cnt;
    bus.a       = va;
    bus.b       = vb;
    bus.carryin = vc;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    for (int i = 0; i < W; i++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_done"}, 64'(bus.done), 64'(1));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, "_carryout"}, 64'(bus.carryout), 64'(exp_co));
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ov));
    @(negedge clk);
    check({tag, "_done_cleared"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int done_cnt;

    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carryin  = 1'b0;
    bus1.start   = 1'b0;
    bus1.a       = '0;
    bus1.b       = '0;
    bus1.carryin = 1'b0;

    // 1. Reset for two cycles with start held high.
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.a       = 8'h5A;
    bus.b       = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_carryout", 64'(bus.carryout), 64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
    check("rst_w1_busy", 64'(bus1.busy), 64'(0));
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_no_run", 64'(bus.busy), 64'(0));

    // 2. Basic add with carry ripple.
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // 3. Carry-out and overflow corners.
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    // 4. Input changes and start pulses while busy are ignored.
    bus.a       = 8'h12;
    bus.b       = 8'h34;
    bus.carryin = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int i = 1; i <= W; i++) begin
      if (i == 2) begin
        bus.a     = 8'hFF;
        bus.start = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      if (i == 4) bus.b = 8'h00;
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("ign_done", 64'(bus.done), 64'(1));
    check("ign_sum", 64'(bus.sum), 64'(8'h46));
    check("ign_single_done", 64'(done_cnt), 64'(1));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_done_start_busy", 64'(bus.busy), 64'(0));
    check("ign_done_start_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    check("ign_not_accepted", 64'(bus.busy), 64'(0));
    check("ign_sum_hold", 64'(bus.sum), 64'(8'h46));

    // 5. Reset in the middle of an operation.
    bus.a       = 8'hAA;
    bus.b       = 8'h55;
    bus.carryin = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_sum", 64'(bus.sum), 64'(0));
    check("mid_rst_carryout", 64'(bus.carryout), 64'(0));
    check("mid_rst_overflow", 64'(bus.overflow), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    check("mid_rst_quiet", 64'(done_cnt), 64'(0));
    run_op("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // 6. Single-bit instance: RUN lasts one cycle, overflow = carryin ^ carryout.
    bus1.a       = 1'b1;
    bus1.b       = 1'b1;
    bus1.carryin = 1'b1;
    bus1.start   = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("w1_busy", 64'(bus1.busy), 64'(1));
    check("w1_not_done_yet", 64'(bus1.done), 64'(0));
    @(negedge clk);
    check("w1_done", 64'(bus1.done), 64'(1));
    check("w1_sum", 64'(bus1.sum), 64'(1));
    check("w1_carryout", 64'(bus1.carryout), 64'(1));
    check("w1_overflow", 64'(bus1.overflow), 64'(0));
    @(negedge clk);
    check("w1_done_cleared", 64'(bus1.done), 64'(0));

    bus1.a       = 1'b0;
    bus1.b       = 1'b0;
    bus1.carryin = 1'b1;
    bus1.start   = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);
    check("w1b_done", 64'(bus1.done), 64'(1));
    check("w1b_sum", 64'(bus1.sum), 64'(1));
    check("w1b_carryout", 64'(bus1.carryout), 64'(0));
    check("w1b_overflow", 64'(bus1.overflow), 64'(1));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
